// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full-adder cell
//
// Purpose: adds two WIDTH-bit operands one bit pair per clock, LSB first,
// through a single full-adder cell (fac). The carry is held in a flip-flop
// between cycles. {co,z} = x + y + ci, and the result is valid after WIDTH RUN cycles.
// Optional feature macro: SERIAL_ADD_SUB_EN. When it is defined, the sub port
// is added and the block computes z = x - y (co=1 means no borrow).
//
// Ports:
//   clk   in   rising-edge clock
//   rst_b in   asynchronous active-low reset
//   sub   in   (SERIAL_ADD_SUB_EN only) subtract request, sampled with start
//   start in   request, sampled only in IDLE
//   x, y  in   WIDTH-bit operands, sampled on accepted start
//   ci    in   carry-in, sampled on accepted start
//   z     out  registered sum, updated only at completion
//   co    out  registered final carry-out, updated only at completion
//   busy  out  high while in RUN
//   done  out  one-cycle completion pulse

module fac (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] z,
  output logic             co,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sx_q, sx_d;
  logic [WIDTH-1:0] sy_q, sy_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;

  logic             sum_bit;
  logic             cell_co;
  logic [WIDTH-1:0] y_load;
  logic             ci_load;

  // Subtraction is two's complement: x + ~y + 1.
`ifdef SERIAL_ADD_SUB_EN
  assign y_load  = sub ? ~y : y;
  assign ci_load = sub ? 1'b1 : ci;
`else
  assign y_load  = y;
  assign ci_load = ci;
`endif

  fac u_fac (
    .a    (sx_q[0]),
    .b    (sy_q[0]),
    .cin  (carry_q),
    .s    (sum_bit),
    .cout (cell_co)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    acc_d   = acc_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sx_d    = x;
          sy_d    = y_load;
          carry_d = ci_load;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB, so after WIDTH shifts bit 0 lands at acc[0].
        acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
        sx_d    = sx_q >> 1;
        sy_d    = sy_q >> 1;
        carry_d = cell_co;
        if (cnt_q == CNT_LAST) begin
          z_d     = acc_d;
          co_d    = cell_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign z    = z_q;
  assign co   = co_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_b;
  logic       start;
  logic [7:0] x, y;
  logic       ci;
  logic [7:0] z;
  logic       co, busy, done;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
`endif

  int checks = 0;
  int passed = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .x     (x),
    .y     (y),
    .ci    (ci),
    .z     (z),
    .co    (co),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: launches one operation and reports latency, busy cycles
  // and the done level one cycle after completion.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, output int lat, output int bcnt,
                        output logic dafter);
    @(negedge clk);
    x = a; y = b; ci = c; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`else
    if (s) $display("note: sub ignored in add-only build");
`endif
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    dafter = done;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst_b = 1'b0; start = 1'b0; x = '0; y = '0; ci = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (z !== 8'h00) $display("FAIL reset_z got %h exp 00", z); else passed++;
    checks++; if (co !== 1'b0) $display("FAIL reset_co got %b exp 0", co); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat, bcnt;
    logic dafter;
    run_op(8'h3C, 8'h5A, 1'b0, 1'b0, lat, bcnt, dafter);
    checks++; if (lat !== 8) $display("FAIL add1_latency got %0d exp 8", lat); else passed++;
    checks++; if (bcnt !== 8) $display("FAIL add1_busy_cycles got %0d exp 8", bcnt); else passed++;
    checks++; if (z !== 8'h96) $display("FAIL add1_z got %h exp 96", z); else passed++;
    checks++; if (co !== 1'b0) $display("FAIL add1_co got %b exp 0", co); else passed++;
    checks++; if (dafter !== 1'b0) $display("FAIL add1_done_one_cycle got %b exp 0", dafter); else passed++;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt, dafter);
    checks++; if (z !== 8'h00) $display("FAIL add2_z got %h exp 00", z); else passed++;
    checks++; if (co !== 1'b1) $display("FAIL add2_co got %b exp 1", co); else passed++;
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bcnt, dafter);
    checks++; if (z !== 8'hFF) $display("FAIL add3_z got %h exp ff", z); else passed++;
    checks++; if (co !== 1'b1) $display("FAIL add3_co got %b exp 1", co); else passed++;
  endtask

  task automatic test_ignore_start;
    int lat, ndone, zbad, bcnt;
    logic dafter;
    // z currently holds FF/1 from the previous operation.
    @(negedge clk);
    x = 8'h0F; y = 8'h01; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = 8'h11; y = 8'h22;
    lat = 0; ndone = 0; zbad = 0;
    for (int k = 0; k < 16; k++) begin
      if (done) ndone++;
      if (!done && z !== 8'hFF) zbad++;
      if (done && ndone == 1) begin
        checks++; if (lat !== 8) $display("FAIL ign_latency got %0d exp 8", lat); else passed++;
        checks++; if (z !== 8'h10) $display("FAIL ign_z got %h exp 10", z); else passed++;
        checks++; if (co !== 1'b0) $display("FAIL ign_co got %b exp 0", co); else passed++;
      end
      start = (k == 2 || k == 6);
      @(negedge clk);
      lat++;
      if (ndone > 0) zbad = 0;
    end
    start = 1'b0;
    checks++; if (ndone !== 1) $display("FAIL ign_done_count got %0d exp 1", ndone); else passed++;
    run_op(8'h11, 8'h22, 1'b0, 1'b0, lat, bcnt, dafter);
    checks++; if (z !== 8'h33) $display("FAIL ign_next_z got %h exp 33", z); else passed++;
    checks++; if (lat !== 8) $display("FAIL ign_next_latency got %0d exp 8", lat); else passed++;
  endtask

  task automatic test_mid_reset;
    int lat, bcnt;
    logic dafter;
    @(negedge clk);
    x = 8'h3C; y = 8'h5A; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL mrst_busy got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL mrst_done got %b exp 0", done); else passed++;
    checks++; if (z !== 8'h00) $display("FAIL mrst_z got %h exp 00", z); else passed++;
    checks++; if (co !== 1'b0) $display("FAIL mrst_co got %b exp 0", co); else passed++;
    @(negedge clk);
    rst_b = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, lat, bcnt, dafter);
    checks++; if (z !== 8'h02) $display("FAIL mrst_after_z got %h exp 02", z); else passed++;
    checks++; if (co !== 1'b0) $display("FAIL mrst_after_co got %b exp 0", co); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, zbad;
    logic dafter;
    @(negedge clk);
    x = 8'h80; y = 8'h80; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (z !== 8'h00 || co !== 1'b1) $display("FAIL b2b_first got %h/%b exp 00/1", z, co); else passed++;
    @(negedge clk);
    x = 8'h12; y = 8'h34; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; zbad = 0;
    while (!done && lat < 40) begin
      if (z !== 8'h00 || co !== 1'b1) zbad++;
      @(negedge clk);
      lat++;
    end
    checks++; if (zbad !== 0) $display("FAIL b2b_hold got %0d changed cycles exp 0", zbad); else passed++;
    checks++; if (lat !== 8) $display("FAIL b2b_latency got %0d exp 8", lat); else passed++;
    checks++; if (z !== 8'h46 || co !== 1'b0) $display("FAIL b2b_second got %h/%b exp 46/0", z, co); else passed++;
    @(negedge clk);
    bcnt = 0; dafter = 1'b0;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int lat, bcnt;
    logic dafter;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, lat, bcnt, dafter);
    checks++; if (z !== 8'h0F || co !== 1'b1) $display("FAIL sub1 got %h/%b exp 0f/1", z, co); else passed++;
    run_op(8'h01, 8'h02, 1'b0, 1'b1, lat, bcnt, dafter);
    checks++; if (z !== 8'hFF || co !== 1'b0) $display("FAIL sub2 got %h/%b exp ff/0", z, co); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
